// File: rtl/mem_access_arbiter_pkg.sv
// Shared types and sizing for the main-memory access arbiter (ICache fills + DCache MSHR traffic).
package mem_access_arbiter_pkg;

  localparam int MSHR_NUM             = 2;
  localparam int MEM_READ_SERIAL_NUM  = MSHR_NUM + 1;
  localparam int MEM_WRITE_SERIAL_NUM = MSHR_NUM;
  localparam int ADDR_W               = 32;
  localparam int DATA_W               = 32;
  localparam int RS_W = (MEM_READ_SERIAL_NUM > 1) ? $clog2(MEM_READ_SERIAL_NUM) : 1;
  localparam int WS_W = (MEM_WRITE_SERIAL_NUM > 1) ? $clog2(MEM_WRITE_SERIAL_NUM) : 1;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [RS_W-1:0]   MemAccessSerial;
  typedef logic [WS_W-1:0]   MemWriteSerial;

  typedef enum logic {MEM_ARB_OWNER_ICACHE, MEM_ARB_OWNER_DCACHE} MemArbOwner;

  typedef struct packed {
    logic  valid;
    addr_t addr;
  } MemReadAccessReq;

  typedef struct packed {
    logic  valid;
    logic  we;
    addr_t addr;
    data_t data;
  } MemAccessReq;

  typedef struct packed {
    logic           ack;
    MemAccessSerial serial;
    MemWriteSerial  wserial;
  } MemAccessReqAck;

  typedef struct packed {
    logic           valid;
    MemAccessSerial serial;
    data_t          data;
  } MemAccessResult;

  typedef struct packed {
    logic          valid;
    MemWriteSerial serial;
  } MemAccessResponse;

endpackage

// File: rtl/mem_access_arbiter_if.sv
// Bundle of cache-side and memory-side signals of the arbiter; slave = arbiter, master = environment.
// Handshake: a request is taken when memReq.valid & memReqReady; the requester holds its request stable until ack.
interface mem_access_arbiter_if;
  import mem_access_arbiter_pkg::*;

  MemReadAccessReq  icReq;
  MemAccessReqAck   icReqAck;
  MemAccessReq      dcReq;
  MemAccessReqAck   dcReqAck;
  MemAccessReq      memReq;
  MemAccessSerial   memReqSerial;
  MemWriteSerial    memReqWSerial;
  logic             memReqReady;
  MemAccessResult   memReadResult;
  MemAccessResponse memWriteResp;
  MemAccessResult   icResult;
  MemAccessResult   dcResult;
  MemAccessResponse dcWriteResp;

  modport slave (
    input  icReq, dcReq, memReqReady, memReadResult, memWriteResp,
    output icReqAck, dcReqAck, memReq, memReqSerial, memReqWSerial, icResult, dcResult, dcWriteResp
  );

  modport master (
    output icReq, dcReq, memReqReady, memReadResult, memWriteResp,
    input  icReqAck, dcReqAck, memReq, memReqSerial, memReqWSerial, icResult, dcResult, dcWriteResp
  );
endinterface

// File: rtl/mem_access_arbiter_serial_free_list.sv
// Busy bitmap with lowest-free encoder; the offered index always comes from the pre-cycle bitmap.
module mem_serial_free_list #(
  parameter int NUM = 2,
  parameter int IW  = (NUM > 1) ? $clog2(NUM) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_alloc,
  input  logic           i_free,
  input  logic [IW-1:0]  i_free_idx,
  output logic [IW-1:0]  o_alloc_idx,
  output logic           o_empty,
  output logic [NUM-1:0] o_busy
);
  logic [NUM-1:0] r_busy;
  logic [NUM-1:0] w_set;
  logic [NUM-1:0] w_clr;
  logic [IW-1:0]  w_idx;

  always_comb begin
    w_idx = '0;
    for (int i = NUM - 1; i >= 0; i--) begin
      if (!r_busy[i]) w_idx = IW'(i);
    end
  end

  // Allocated entries are free and freed entries are busy, so the masks never overlap.
  assign w_set = {{(NUM-1){1'b0}}, (i_alloc & ~o_empty)} << w_idx;
  assign w_clr = {{(NUM-1){1'b0}}, i_free} << i_free_idx;

  always_ff @(posedge clk) begin
    if (rst) r_busy <= '0;
    else     r_busy <= (r_busy | w_set) & ~w_clr;
  end

  assign o_alloc_idx = w_idx;
  assign o_empty     = &r_busy;
  assign o_busy      = r_busy;
endmodule

// File: rtl/mem_access_arbiter.sv
// Arbitrates ICache/DCache access to the memory port, allocates serials and routes returns to their owner.
// Define MEM_ACCESS_ARBITER_FIXED_PRIORITY_EN to make ICache win every contended cycle (no RR pointer).
module mem_access_arbiter
  import mem_access_arbiter_pkg::*;
(
  input logic                  clk,
  input logic                  rst,
  mem_access_arbiter_if.slave  bus
);
  logic           w_rd_empty, w_wr_empty;
  MemAccessSerial w_rd_idx;
  MemWriteSerial  w_wr_idx;
  logic [MEM_READ_SERIAL_NUM-1:0]  w_rd_busy;
  logic [MEM_WRITE_SERIAL_NUM-1:0] w_wr_busy;
  logic w_ic_elig, w_dc_elig, w_gnt_ic, w_gnt_dc, w_accept;
  logic w_rd_alloc, w_wr_alloc, w_rd_hit, w_wr_hit;

  MemArbOwner       r_owner [MEM_READ_SERIAL_NUM];
  MemAccessResult   r_ic_result, r_dc_result;
  MemAccessResponse r_wr_resp;

  assign w_ic_elig = ~rst & bus.icReq.valid & ~w_rd_empty;
  assign w_dc_elig = ~rst & bus.dcReq.valid & (bus.dcReq.we ? ~w_wr_empty : ~w_rd_empty);

`ifdef MEM_ACCESS_ARBITER_FIXED_PRIORITY_EN
  assign w_gnt_ic = w_ic_elig;
`else
  MemArbOwner r_rr_ptr;
  assign w_gnt_ic = w_ic_elig & (~w_dc_elig | (r_rr_ptr == MEM_ARB_OWNER_ICACHE));

  always_ff @(posedge clk) begin
    if (rst) r_rr_ptr <= MEM_ARB_OWNER_ICACHE;
    else if (w_accept && w_ic_elig && w_dc_elig)
      r_rr_ptr <= w_gnt_ic ? MEM_ARB_OWNER_DCACHE : MEM_ARB_OWNER_ICACHE;
  end
`endif

  assign w_gnt_dc   = w_dc_elig & ~w_gnt_ic;
  assign w_accept   = (w_gnt_ic | w_gnt_dc) & bus.memReqReady;
  assign w_rd_alloc = w_accept & (w_gnt_ic | ~bus.dcReq.we);
  assign w_wr_alloc = w_accept & w_gnt_dc & bus.dcReq.we;

  // Returns for serials that are not busy are stale (e.g. issued before a reset) and ignored.
  assign w_rd_hit = bus.memReadResult.valid &&
                    (int'(bus.memReadResult.serial) < MEM_READ_SERIAL_NUM) &&
                    w_rd_busy[bus.memReadResult.serial];
  assign w_wr_hit = bus.memWriteResp.valid && w_wr_busy[bus.memWriteResp.serial];

  always_comb begin
    bus.memReq = '0;
    if (w_gnt_ic) begin
      bus.memReq.valid = 1'b1;
      bus.memReq.addr  = bus.icReq.addr;
    end else if (w_gnt_dc) begin
      bus.memReq = bus.dcReq;
    end
  end

  always_comb begin
    bus.icReqAck         = '0;
    bus.dcReqAck         = '0;
    bus.icReqAck.ack     = w_accept & w_gnt_ic;
    bus.icReqAck.serial  = w_rd_idx;
    bus.dcReqAck.ack     = w_accept & w_gnt_dc;
    bus.dcReqAck.serial  = w_rd_idx;
    bus.dcReqAck.wserial = w_wr_idx;
  end

  assign bus.memReqSerial  = w_rd_idx;
  assign bus.memReqWSerial = w_wr_idx;

  mem_serial_free_list #(.NUM(MEM_READ_SERIAL_NUM), .IW(RS_W)) u_rd_list (
    .clk(clk), .rst(rst), .i_alloc(w_rd_alloc), .i_free(w_rd_hit),
    .i_free_idx(bus.memReadResult.serial), .o_alloc_idx(w_rd_idx),
    .o_empty(w_rd_empty), .o_busy(w_rd_busy)
  );

  mem_serial_free_list #(.NUM(MEM_WRITE_SERIAL_NUM), .IW(WS_W)) u_wr_list (
    .clk(clk), .rst(rst), .i_alloc(w_wr_alloc), .i_free(w_wr_hit),
    .i_free_idx(bus.memWriteResp.serial), .o_alloc_idx(w_wr_idx),
    .o_empty(w_wr_empty), .o_busy(w_wr_busy)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MEM_READ_SERIAL_NUM; i++) r_owner[i] <= MEM_ARB_OWNER_ICACHE;
      r_ic_result <= '0;
      r_dc_result <= '0;
      r_wr_resp   <= '0;
    end else begin
      if (w_rd_alloc) r_owner[w_rd_idx] <= w_gnt_ic ? MEM_ARB_OWNER_ICACHE : MEM_ARB_OWNER_DCACHE;
      r_ic_result       <= bus.memReadResult;
      r_ic_result.valid <= w_rd_hit & (r_owner[bus.memReadResult.serial] == MEM_ARB_OWNER_ICACHE);
      r_dc_result       <= bus.memReadResult;
      r_dc_result.valid <= w_rd_hit & (r_owner[bus.memReadResult.serial] == MEM_ARB_OWNER_DCACHE);
      r_wr_resp         <= bus.memWriteResp;
      r_wr_resp.valid   <= w_wr_hit;
    end
  end

  assign bus.icResult    = r_ic_result;
  assign bus.dcResult    = r_dc_result;
  assign bus.dcWriteResp = r_wr_resp;
endmodule
